reorder_buffer: RTL
===================

# reorder_buffer

In-order retirement buffer for the out-of-order pipeline. It allocates one entry per cycle at dispatch and captures results from the common data bus (CDB). It supplies operand values to the allocator for tags that have already produced results. It retires the head entry in program order toward the register file. It replaces the inline ROB array and head/tail logic in the dispatch stage, and sits between dispatch (upstream) and register-file writeback (downstream).

## Interface
Parameters:
- ROB_SIZE, 16, number of entries; power of two, 4..64
- DATA_WIDTH, 64, result width
- TAG_W, $clog2(ROB_SIZE+1), tag width; tags are 1..ROB_SIZE, 0 means "no tag"

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; state clears immediately while low
- alloc_valid  in  1  dispatch requests an entry this cycle
- alloc_rd  in  5  destination register (0 = none)
- alloc_pc  in  64  instruction PC
- alloc_tag  out  TAG_W  tag the next allocation receives (= tail)
- alloc_accept  out  1  alloc_valid && !full
- full  out  1  count == ROB_SIZE
- empty  out  1  count == 0
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  producing tag
- cdb_value  in  DATA_WIDTH  result
- rd_tag_a, rd_tag_b  in  TAG_W  operand lookup tags
- rd_ready_a, rd_ready_b  out  1  entry allocated and done
- rd_value_a, rd_value_b  out  DATA_WIDTH  entry value; 0 when not ready
- commit_valid  out  1  head retired this cycle
- commit_tag  out  TAG_W  retired tag
- commit_rd  out  5  retired destination
- commit_value  out  DATA_WIDTH  retired result
- commit_pc  out  64  retired PC
- flush  in  1  discard all entries (mispredict recovery)

## Operation
- Entry fields: busy, done, rd, pc, value. Head, tail and count are registered. Tags are index+1.
- Allocate when alloc_accept: entry[tail] gets busy=1, done=0, rd, pc, value=0. Tail advances; ROB_SIZE wraps to 1.
- CDB write: when cdb_valid, cdb_tag!=0 and entry busy, set done=1 and value=cdb_value. Writes to tag 0 or to a non-busy entry are ignored. A write to an entry that is already done overwrites it (last write wins).
- Commit: when head entry is busy && done, retire it. Outputs are registered and valid for the following cycle. Clear busy, advance head with wrap. At most one commit per cycle.
- count next = count + accept − commit. Allocate and commit together when full: full is evaluated before the commit, so alloc is rejected. Allocate and commit together when not full: both happen and count is unchanged.
- Simultaneous CDB write and allocate to the same tag cannot occur (the tag is not busy). The CDB write is ignored.
- Read ports are combinational. Tag 0 or a non-busy entry gives ready=0, value=0.
- flush (synchronous) has priority over alloc, CDB and commit. It clears all busy/done bits and sets head=tail=1, count=0, commit_valid=0 next cycle.
- Reset low: head=tail=1, count=0, all entries cleared. All outputs read 0 except alloc_tag=1 and empty=1.

## Timing
- Allocation in cycle t makes the entry visible from t+1.
- CDB write in cycle t sets done from t+1. Earliest commit is evaluated in t+1, and commit_valid is high in t+2.
- commit_valid is a single-cycle pulse per retired entry. Back-to-back done entries retire one per cycle.
- full/empty are combinational from the registered count.
- Reset deassertion takes effect on the first rising edge after reset goes high.

## Configuration
- ROB_CDB_BYPASS_EN defined: read ports forward the same-cycle CDB write. If cdb_valid and cdb_tag equals rd_tag_x and the entry is busy, the port gives ready=1 and value=cdb_value in that cycle.
- Not defined: read ports reflect registered state only. The result is seen one cycle after the CDB write.

## Test plan
- Reset low mid-operation with count=5 -> immediately empty=1, alloc_tag=1, commit_valid=0; after release, first alloc gets tag 1.
- Allocate 16 entries, then alloc_valid=1 -> full=1, alloc_accept=0, alloc_tag=1 (wrapped), count stays 16.
- Allocate tags 1,2,3. CDB writes tag 3=0x33 then tag 1=0x11 -> commit tag 1 (value 0x11) only. Then CDB tag 2=0x22 -> commits tag 2 then tag 3 in consecutive cycles, in order.
- CDB tag 5 value 0xAB with rd_tag_a=5 in the same cycle -> ready_a=1, value 0xAB that cycle with ROB_CDB_BYPASS_EN, one cycle later without it.
- Full buffer, head done, alloc_valid=1 -> commit occurs, alloc rejected that cycle; next cycle alloc accepted and count returns to 16.
- Six live entries, flush=1 with a simultaneous alloc and CDB write -> next cycle empty=1, no commit, alloc_tag=1.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand-lookup and commit signals of the reorder buffer.
// master = pipeline side driving requests, slave = the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_W      = 5
);
    logic                  alloc_valid;
    logic [4:0]            alloc_rd;
    logic [63:0]           alloc_pc;
    logic [TAG_W-1:0]      alloc_tag;
    logic                  alloc_accept;
    logic                  full;
    logic                  empty;

    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_value;

    logic [TAG_W-1:0]      rd_tag_a;
    logic [TAG_W-1:0]      rd_tag_b;
    logic                  rd_ready_a;
    logic                  rd_ready_b;
    logic [DATA_WIDTH-1:0] rd_value_a;
    logic [DATA_WIDTH-1:0] rd_value_b;

    logic                  commit_valid;
    logic [TAG_W-1:0]      commit_tag;
    logic [4:0]            commit_rd;
    logic [DATA_WIDTH-1:0] commit_value;
    logic [63:0]           commit_pc;

    logic                  flush;

    modport master (
        output alloc_valid, alloc_rd, alloc_pc,
        output cdb_valid, cdb_tag, cdb_value,
        output rd_tag_a, rd_tag_b, flush,
        input  alloc_tag, alloc_accept, full, empty,
        input  rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
        input  commit_valid, commit_tag, commit_rd, commit_value, commit_pc
    );

    modport slave (
        input  alloc_valid, alloc_rd, alloc_pc,
        input  cdb_valid, cdb_tag, cdb_value,
        input  rd_tag_a, rd_tag_b, flush,
        output alloc_tag, alloc_accept, full, empty,
        output rd_ready_a, rd_ready_b, rd_value_a, rd_value_b,
        output commit_valid, commit_tag, commit_rd, commit_value, commit_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at dispatch, capture CDB results, retire head in order.
// Optional macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB write onto the operand read ports.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE   = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned TAG_W      = $clog2(ROB_SIZE + 1)
) (
    input logic             clk,
    input logic             reset,
    reorder_buffer_if.slave rob
);
    localparam int unsigned IDX_W = $clog2(ROB_SIZE);
    localparam int unsigned CNT_W = $clog2(ROB_SIZE + 1);
    localparam int unsigned RD_W  = 5;
    localparam int unsigned PC_W  = 64;
    localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_LAST  = TAG_W'(ROB_SIZE);

    logic [ROB_SIZE-1:0]   busy_q;
    logic [ROB_SIZE-1:0]   done_q;
    logic [RD_W-1:0]       rd_q    [ROB_SIZE];
    logic [PC_W-1:0]       pc_q    [ROB_SIZE];
    logic [DATA_WIDTH-1:0] value_q [ROB_SIZE];

    logic [TAG_W-1:0]      head_q;
    logic [TAG_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;

    logic                  commit_valid_q;
    logic [TAG_W-1:0]      commit_tag_q;
    logic [RD_W-1:0]       commit_rd_q;
    logic [DATA_WIDTH-1:0] commit_value_q;
    logic [PC_W-1:0]       commit_pc_q;

    logic                  full_w;
    logic                  accept_w;
    logic [IDX_W-1:0]      head_idx;
    logic [IDX_W-1:0]      tail_idx;
    logic [IDX_W-1:0]      cdb_idx;
    logic                  commit_fire;
    logic                  cdb_hit;

    // Tags are index+1; tag 0 and out-of-range tags never address an entry.
    function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
        return IDX_W'(t - TAG_FIRST);
    endfunction

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= TAG_LAST);
    endfunction

    function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] t);
        return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
    endfunction

    always_comb begin
        full_w      = (count_q == CNT_W'(ROB_SIZE));
        accept_w    = rob.alloc_valid && !full_w;
        head_idx    = tag_idx(head_q);
        tail_idx    = tag_idx(tail_q);
        cdb_idx     = tag_idx(rob.cdb_tag);
        commit_fire = busy_q[head_idx] && done_q[head_idx];
        cdb_hit     = rob.cdb_valid && tag_ok(rob.cdb_tag) && busy_q[cdb_idx];
    end

    // Entry array, pointers and registered commit port; flush overrides everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= TAG_FIRST;
            tail_q         <= TAG_FIRST;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_pc_q    <= '0;
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                rd_q[i]    <= '0;
                pc_q[i]    <= '0;
                value_q[i] <= '0;
            end
        end else if (rob.flush) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= TAG_FIRST;
            tail_q         <= TAG_FIRST;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
        end else begin
            if (accept_w) begin
                busy_q[tail_idx]  <= 1'b1;
                done_q[tail_idx]  <= 1'b0;
                rd_q[tail_idx]    <= rob.alloc_rd;
                pc_q[tail_idx]    <= rob.alloc_pc;
                value_q[tail_idx] <= '0;
                tail_q            <= tag_next(tail_q);
            end
            if (cdb_hit) begin
                done_q[cdb_idx]  <= 1'b1;
                value_q[cdb_idx] <= rob.cdb_value;
            end
            // Retiring entry is cleared after the CDB update so a late write cannot revive it.
            if (commit_fire) begin
                busy_q[head_idx] <= 1'b0;
                done_q[head_idx] <= 1'b0;
                head_q           <= tag_next(head_q);
                commit_tag_q     <= head_q;
                commit_rd_q      <= rd_q[head_idx];
                commit_value_q   <= value_q[head_idx];
                commit_pc_q      <= pc_q[head_idx];
            end
            commit_valid_q <= commit_fire;
            count_q        <= count_q + CNT_W'(accept_w) - CNT_W'(commit_fire);
        end
    end

    // Operand lookup ports, one generate instance per port.
    logic [TAG_W-1:0] lookup_tag [2];
    assign lookup_tag[0] = rob.rd_tag_a;
    assign lookup_tag[1] = rob.rd_tag_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [IDX_W-1:0]      idx;
        logic                  live;
        logic                  ready;
        logic [DATA_WIDTH-1:0] value;

        always_comb begin
            idx   = tag_idx(lookup_tag[p]);
            live  = tag_ok(lookup_tag[p]) && busy_q[idx];
            ready = live && done_q[idx];
            value = ready ? value_q[idx] : '0;
`ifdef ROB_CDB_BYPASS_EN
            if (live && rob.cdb_valid && (rob.cdb_tag == lookup_tag[p])) begin
                ready = 1'b1;
                value = rob.cdb_value;
            end
`endif
        end
    end

    assign rob.rd_ready_a   = g_rd[0].ready;
    assign rob.rd_value_a   = g_rd[0].value;
    assign rob.rd_ready_b   = g_rd[1].ready;
    assign rob.rd_value_b   = g_rd[1].value;

    assign rob.alloc_tag    = tail_q;
    assign rob.alloc_accept = accept_w;
    assign rob.full         = full_w;
    assign rob.empty        = (count_q == '0);

    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_tag   = commit_tag_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_value = commit_value_q;
    assign rob.commit_pc    = commit_pc_q;
endmodule
